// File: rtl/reg_scoreboard_if.sv
// Issue/writeback/status bundle between decode and reg_scoreboard.
// master = decode/issue side, slave = scoreboard.
interface reg_scoreboard_if;
    logic        flush;
    logic        issue_vld;
    logic [3:0]  issue_rd;
    logic        issue_wr;
    logic [3:0]  src1;
    logic        src1_use;
    logic [3:0]  src2;
    logic        src2_use;
    logic        wb_vld;
    logic [3:0]  wb_rd;
    logic        issue_rdy;
    logic        stall;
    logic [15:0] busy;
    logic        err;

    modport master (
        output flush, issue_vld, issue_rd, issue_wr,
        output src1, src1_use, src2, src2_use, wb_vld, wb_rd,
        input  issue_rdy, stall, busy, err
    );

    modport slave (
        input  flush, issue_vld, issue_rd, issue_wr,
        input  src1, src1_use, src2, src2_use, wb_vld, wb_rd,
        output issue_rdy, stall, busy, err
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Hazard scoreboard: 2-bit pending-write counter per register, R0 hardwired idle.
// Define SCOREBOARD_BYPASS_EN to let a consumer issue in its producer's last writeback cycle.
module reg_scoreboard (
    input  logic            clk,
    input  logic            rst,
    reg_scoreboard_if.slave sb
);
    logic [1:0]  cnt_q [16];
    logic [1:0]  cnt_d [16];
    logic [15:0] busy_q;
    logic [15:0] busy_d;
    logic        err_q;
    logic        err_d;
    logic [15:0] inc_s;
    logic [15:0] dec_s;
    logic        byp1_s;
    logic        byp2_s;
    logic        haz1_s;
    logic        haz2_s;
    logic        stall_s;
    logic        full_s;
    logic        rdy_s;
    logic        accept_s;

    function automatic logic cnt_busy(input logic [1:0] c);
        return (c != 2'd0);
    endfunction

    // Forwarding window: the final writeback of a source may satisfy its consumer.
    always_comb begin
`ifdef SCOREBOARD_BYPASS_EN
        byp1_s = sb.wb_vld & (sb.wb_rd == sb.src1) & (cnt_q[sb.src1] == 2'd1);
        byp2_s = sb.wb_vld & (sb.wb_rd == sb.src2) & (cnt_q[sb.src2] == 2'd1);
`else
        byp1_s = 1'b0;
        byp2_s = 1'b0;
`endif
    end

    // Hazard, capacity and issue handshake from registered counts and current inputs.
    always_comb begin
        haz1_s   = sb.src1_use & (sb.src1 != 4'd0) & cnt_busy(cnt_q[sb.src1]) & ~byp1_s;
        haz2_s   = sb.src2_use & (sb.src2 != 4'd0) & cnt_busy(cnt_q[sb.src2]) & ~byp2_s;
        stall_s  = haz1_s | haz2_s;
        full_s   = sb.issue_wr & (sb.issue_rd != 4'd0) & (cnt_q[sb.issue_rd] == 2'd3);
        rdy_s    = sb.issue_vld & ~stall_s & ~full_s & ~sb.flush;
        accept_s = rdy_s & sb.issue_wr & (sb.issue_rd != 4'd0);
    end

    // Per-register increment/decrement requests; a decrement needs a nonzero count.
    always_comb begin
        inc_s = 16'h0000;
        dec_s = 16'h0000;
        for (int i = 1; i < 16; i++) begin
            inc_s[i] = accept_s & (sb.issue_rd == 4'(i));
            dec_s[i] = sb.wb_vld & (sb.wb_rd == 4'(i)) & cnt_busy(cnt_q[i]);
        end
    end

    // Next counts, busy image and sticky error.
    always_comb begin
        cnt_d[0]  = 2'd0;
        busy_d    = 16'h0000;
        for (int i = 1; i < 16; i++) begin
            if (sb.flush) begin
                cnt_d[i] = 2'd0;
            end else begin
                case ({inc_s[i], dec_s[i]})
                    2'b10:   cnt_d[i] = cnt_q[i] + 2'd1;
                    2'b01:   cnt_d[i] = cnt_q[i] - 2'd1;
                    default: cnt_d[i] = cnt_q[i];
                endcase
            end
            busy_d[i] = cnt_busy(cnt_d[i]);
        end
        if (!sb.flush && sb.wb_vld && (sb.wb_rd != 4'd0) && (cnt_q[sb.wb_rd] == 2'd0)) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // State registers; reset discards all pending writes immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                cnt_q[i] <= 2'd0;
            end
            busy_q <= 16'h0000;
            err_q  <= 1'b0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign sb.issue_rdy = rdy_s;
    assign sb.stall     = stall_s;
    assign sb.busy      = busy_q;
    assign sb.err       = err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard with hand-computed expectations.
module tb_reg_scoreboard;
    logic clk;
    logic rst;
    int   chk_cnt;
    int   pass_cnt;

    reg_scoreboard_if sb_if ();

    reg_scoreboard dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        sb_if.flush     = 1'b0;
        sb_if.issue_vld = 1'b0;
        sb_if.issue_rd  = 4'd0;
        sb_if.issue_wr  = 1'b0;
        sb_if.src1      = 4'd0;
        sb_if.src1_use  = 1'b0;
        sb_if.src2      = 4'd0;
        sb_if.src2_use  = 1'b0;
        sb_if.wb_vld    = 1'b0;
        sb_if.wb_rd     = 4'd0;
    endtask

    // advance one clock, then leave time for registered outputs to settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_issue(input logic [3:0] rd);
        idle();
        sb_if.issue_vld = 1'b1;
        sb_if.issue_wr  = 1'b1;
        sb_if.issue_rd  = rd;
    endtask

    task automatic drive_wb(input logic [3:0] rd);
        idle();
        sb_if.wb_vld = 1'b1;
        sb_if.wb_rd  = rd;
    endtask

    initial begin
        logic exp_byp_stall;
`ifdef SCOREBOARD_BYPASS_EN
        exp_byp_stall = 1'b0;
`else
        exp_byp_stall = 1'b1;
`endif
        chk_cnt  = 0;
        pass_cnt = 0;
        rst      = 1'b1;
        idle();
        #3;
        check("rst_busy", 32'(sb_if.busy), 32'h0000);
        check("rst_err", 32'(sb_if.err), 32'h0);
        sb_if.issue_vld = 1'b1;
        #1;
        check("rst_rdy", 32'(sb_if.issue_rdy), 32'h1);
        check("rst_stall", 32'(sb_if.stall), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // basic issue to R5
        @(posedge clk); #1;
        drive_issue(4'd5);
        #1;
        check("iss5_rdy", 32'(sb_if.issue_rdy), 32'h1);
        tick();
        check("iss5_busy", 32'(sb_if.busy), 32'h0020);

        // consumer of R5
        idle();
        sb_if.issue_vld = 1'b1;
        sb_if.src1      = 4'd5;
        sb_if.src1_use  = 1'b1;
        #1;
        check("haz1_stall", 32'(sb_if.stall), 32'h1);
        check("haz1_rdy", 32'(sb_if.issue_rdy), 32'h0);
        sb_if.src1_use = 1'b0;
        #1;
        check("nouse_stall", 32'(sb_if.stall), 32'h0);
        sb_if.src2     = 4'd5;
        sb_if.src2_use = 1'b1;
        #1;
        check("haz2_stall", 32'(sb_if.stall), 32'h1);
        sb_if.wb_vld = 1'b1;
        sb_if.wb_rd  = 4'd5;
        #1;
        check("wb_cyc_stall", 32'(sb_if.stall), 32'(exp_byp_stall));
        tick();
        check("wb5_busy", 32'(sb_if.busy), 32'h0000);
        sb_if.wb_vld = 1'b0;
        #1;
        check("post_wb_stall", 32'(sb_if.stall), 32'h0);
        check("post_wb_rdy", 32'(sb_if.issue_rdy), 32'h1);
        tick();

        // fill R7 to capacity
        for (int k = 0; k < 3; k++) begin
            drive_issue(4'd7);
            #1;
            check("fill7_rdy", 32'(sb_if.issue_rdy), 32'h1);
            tick();
        end
        check("fill7_busy", 32'(sb_if.busy), 32'h0080);
        drive_issue(4'd7);
        #1;
        check("full7_rdy", 32'(sb_if.issue_rdy), 32'h0);
        sb_if.issue_wr = 1'b0;
        #1;
        check("full7_nowr_rdy", 32'(sb_if.issue_rdy), 32'h1);
        sb_if.issue_wr = 1'b1;
        sb_if.wb_vld   = 1'b1;
        sb_if.wb_rd    = 4'd7;
        #1;
        check("full7_wb_rdy", 32'(sb_if.issue_rdy), 32'h0);
        tick();
        // cnt[7]=2: one wb leaves it busy, same-cycle issue+wb holds at 1, last wb clears
        drive_wb(4'd7);
        tick();
        check("r7_cnt1_busy", 32'(sb_if.busy), 32'h0080);
        drive_issue(4'd7);
        sb_if.wb_vld = 1'b1;
        sb_if.wb_rd  = 4'd7;
        #1;
        check("r7_issue_wb_rdy", 32'(sb_if.issue_rdy), 32'h1);
        tick();
        check("r7_hold_busy", 32'(sb_if.busy), 32'h0080);
        drive_wb(4'd7);
        tick();
        check("r7_empty_busy", 32'(sb_if.busy), 32'h0000);
        check("r7_err", 32'(sb_if.err), 32'h0);

        // R0 never tracked
        for (int k = 0; k < 4; k++) begin
            drive_issue(4'd0);
            sb_if.src1_use = 1'b1;
            #1;
            check("r0_stall", 32'(sb_if.stall), 32'h0);
            tick();
        end
        check("r0_busy", 32'(sb_if.busy), 32'h0000);
        drive_wb(4'd0);
        tick();
        check("r0_wb_err", 32'(sb_if.err), 32'h0);

        // wb underflow with same-cycle issue: net count 1, err set
        drive_issue(4'd3);
        sb_if.wb_vld = 1'b1;
        sb_if.wb_rd  = 4'd3;
        tick();
        check("uf_err", 32'(sb_if.err), 32'h1);
        check("uf_net_busy", 32'(sb_if.busy), 32'h0008);
        drive_wb(4'd3);
        tick();
        check("uf_busy", 32'(sb_if.busy), 32'h0000);

        // flush with pending R2/R9 and a competing issue
        drive_issue(4'd2); tick();
        drive_issue(4'd2); tick();
        drive_issue(4'd9); tick();
        check("pre_flush_busy", 32'(sb_if.busy), 32'h0204);
        drive_issue(4'd4);
        sb_if.flush = 1'b1;
        #1;
        check("flush_rdy", 32'(sb_if.issue_rdy), 32'h0);
        tick();
        check("flush_busy", 32'(sb_if.busy), 32'h0000);
        check("flush_err", 32'(sb_if.err), 32'h1);

        // asynchronous reset mid-cycle
        drive_issue(4'd5); tick();
        idle();
        check("pre_rst_busy", 32'(sb_if.busy), 32'h0020);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", 32'(sb_if.busy), 32'h0000);
        check("arst_err", 32'(sb_if.err), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Hazard scoreboard for the 16-entry register file. It tracks outstanding writes per destination register and raises a stall when an instruction's source registers have pending results. Sits between decode/issue and the register file read ports. Uses the same 4-bit register IDs that drive the register file read/write decoders.

## Interface
- MAXPEND, 3: maximum outstanding writes tracked per register; counter width is 2 bits, fixed.
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  pipeline flush; clears all pending counts.
- issue_vld  in  1  decode presents an instruction.
- issue_rd  in  4  destination register ID.
- issue_wr  in  1  instruction writes issue_rd.
- src1  in  4  first source register ID.
- src1_use  in  1  src1 is read by the instruction.
- src2  in  4  second source register ID.
- src2_use  in  1  src2 is read by the instruction.
- wb_vld  in  1  writeback retires one write.
- wb_rd  in  4  writeback destination ID.
- issue_rdy  out  1  instruction may issue this cycle.
- stall  out  1  source hazard present (combinational).
- busy  out  16  bit i set when cnt[i] != 0.
- err  out  1  sticky: writeback to a register with count 0.

## Operation
- State: cnt[15:0], 2 bits each, and an err flag. R0 is hardwired zero: cnt[0] is never incremented, busy[0]=0, and R0 never causes a hazard.
- hazN = srcN_use & (srcN != 0) & (cnt[srcN] != 0). stall = haz1 | haz2.
- full = issue_wr & (issue_rd != 0) & (cnt[issue_rd] == 3).
- issue_rdy = issue_vld & ~stall & ~full & ~flush.
- Accepted issue (issue_rdy & issue_wr & issue_rd != 0) increments cnt[issue_rd].
- wb_vld with wb_rd != 0 decrements cnt[wb_rd]. If cnt[wb_rd] == 0, the count stays 0 and err is set. err clears only on reset.
- Accepted issue and wb to the same register in the same cycle leave the count unchanged. An issue at cnt == 3 is not accepted, so no overflow occurs. Same-cycle wb from 0 with issue gives net 1 and sets err.
- flush: all cnt go to 0 next cycle. Issue and wb that cycle are ignored; err is unaffected.
- wb_rd == 0: ignored, no err.

## Timing
- Reset (async assert): cnt all 0, busy=0, err=0. Hence stall=0 and issue_rdy=issue_vld.
- stall, issue_rdy: combinational from registered cnt and current inputs. No registered latency.
- busy, err: registered and updated on the clk edge. busy reflects the state after the edge.
- Count updates are visible to stall one cycle after the issue/wb edge. A back-to-back dependent instruction stalls from the cycle after its producer issues.
- Reset mid-operation discards all pending state immediately, regardless of clk.

## Configuration
- SCOREBOARD_BYPASS_EN defined: hazN is suppressed when wb_vld & (wb_rd == srcN) & (cnt[srcN] == 1). This lets a consumer issue in the writeback cycle, with datapath forwarding supplying the value.
- Undefined: no suppression. The consumer issues one cycle after the final writeback.

## Test plan
- Reset, then issue_vld=1, issue_wr=1, rd=5, no src use -> issue_rdy=1; next cycle busy=0x0020.
- cnt[5]=1, instruction with src1=5, src1_use=1 -> stall=1, issue_rdy=0. Then wb rd=5 -> busy=0x0000 next cycle and stall=0. With SCOREBOARD_BYPASS_EN, stall=0 already in the wb cycle.
- Three issues to rd=7 without wb -> cnt[7]=3. Fourth issue to rd=7 -> issue_rdy=0. A simultaneous wb rd=7 on the fourth attempt still gives issue_rdy=0 and cnt[7]=2 next cycle.
- Issue rd=0 repeatedly and src1=0 -> busy[0]=0 and stall=0 always. A wb with rd=0 leaves err=0.
- wb rd=3 with cnt[3]=0 -> err=1 and cnt[3]=0. err stays 1 after flush and clears only on rst.
- cnt[2]=2, cnt[9]=1, assert flush together with issue rd=4 -> issue_rdy=0 and busy=0x0000 next cycle. Assert rst asynchronously mid-sequence -> busy=0 immediately.
